pipeline_mem: RTL and testbench

Memory-access stage of the 5-stage core; consumes the execute-stage result bundle (ex_res, r2_val_mem, mem_dst_reg, next_mem_opcode, next_mem_operation_size, ecall_mem) and returns backpressure through its ready output (execute stage's next_stage_ready).
Issues loads/stores on a single-outstanding request/grant/response data-memory bus and sign- or zero-extends load data.
Registers one writeback bundle toward the writeback stage with a valid/ready handshake.

---
 rtl/pipeline_mem.sv | 146 ++++++++++++++
 tb/tb_pipeline_mem.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_mem.sv
// pipeline_mem: memory-access stage; MEM_MISALIGN_CHECK_EN turns misaligned accesses into faults.
module pipeline_mem #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic [DATA_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val_mem,
  input  logic [4:0]            mem_dst_reg,
  input  logic [31:0]           next_mem_opcode,
  input  logic [2:0]            next_mem_operation_size,
  input  logic                  ecall_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [7:0]            mem_wstrb,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  wb_ecall,
  output logic                  wb_fault
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic                  w_cap, w_is_ld, w_is_st, w_is_mem, w_mis, w_sx, w_req;
  logic [2:0]            w_amask, w_lane;
  logic [7:0]            w_strb0;
  logic [DATA_WIDTH-1:0] w_raw, w_ext;
  logic [DATA_WIDTH-1:0] r_ex, r_wdata, r_ldata;
  logic [7:0]            r_strb;
  logic                  r_we, r_mis;
  logic [2:0]            r_size, r_lane;
  logic [4:0]            r_dst;
  logic                  r_wb_valid, r_wb_ecall, r_wb_fault;
  logic [4:0]            r_wb_dst;
  logic [DATA_WIDTH-1:0] r_wb_data;
  assign w_is_ld  = next_mem_opcode == 32'd1;
  assign w_is_st  = next_mem_opcode == 32'd2;
  assign w_is_mem = (w_is_ld || w_is_st) && !ecall_mem;
  assign ready    = !reset && r_state == IDLE && (!r_wb_valid || wb_ready);
  assign w_cap    = in_valid && ready;
  assign w_amask  = next_mem_operation_size[1:0] == 2'd0 ? 3'b000 :
                    next_mem_operation_size[1:0] == 2'd1 ? 3'b001 :
                    next_mem_operation_size[1:0] == 2'd2 ? 3'b011 : 3'b111;
  assign w_strb0  = next_mem_operation_size[1:0] == 2'd0 ? 8'h01 :
                    next_mem_operation_size[1:0] == 2'd1 ? 8'h03 :
                    next_mem_operation_size[1:0] == 2'd2 ? 8'h0F : 8'hFF;
`ifdef MEM_MISALIGN_CHECK_EN
  assign w_lane = ex_res[2:0];
  assign w_mis  = |(ex_res[2:0] & w_amask);
`else
  // Round the lane down to natural alignment so the access stays inside one doubleword.
  assign w_lane = ex_res[2:0] & ~w_amask;
  assign w_mis  = 1'b0;
`endif
  assign w_raw = mem_rdata >> {r_lane, 3'b000};
  assign w_sx  = !r_size[2];
  assign w_ext = r_size[1:0] == 2'd0 ? {{(DATA_WIDTH-8){w_sx & w_raw[7]}}, w_raw[7:0]} :
                 r_size[1:0] == 2'd1 ? {{(DATA_WIDTH-16){w_sx & w_raw[15]}}, w_raw[15:0]} :
                 r_size[1:0] == 2'd2 ? {{(DATA_WIDTH-32){w_sx & w_raw[31]}}, w_raw[31:0]} : w_raw;
  assign mem_req   = w_req && !reset;
  assign mem_we    = mem_req && r_we;
  assign mem_addr  = mem_req ? {r_ex[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign mem_wdata = mem_we ? r_wdata : '0;
  assign mem_wstrb = mem_we ? r_strb : 8'h00;
  assign wb_valid   = r_wb_valid;
  assign wb_dst_reg = r_wb_dst;
  assign wb_data    = r_wb_data;
  assign wb_ecall   = r_wb_ecall;
  assign wb_fault   = r_wb_fault;
  // State register.
  always_ff @(posedge clk)
    r_state <= reset ? IDLE : w_next;
  // Next-state and bus request.
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    case (r_state)
      IDLE: if (w_cap && w_is_mem) w_next = w_mis ? DONE : REQ;
      REQ: begin
        w_req = 1'b1;
        if (mem_gnt) w_next = r_we ? DONE : WAIT;
      end
      WAIT: if (mem_rvalid) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  // Latch the memory bundle at capture and the extended load data on response.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex    <= '0;
      r_wdata <= '0;
      r_strb  <= 8'h00;
      r_we    <= 1'b0;
      r_size  <= 3'd0;
      r_lane  <= 3'd0;
      r_dst   <= 5'd0;
      r_mis   <= 1'b0;
      r_ldata <= '0;
    end else begin
      if (w_cap && w_is_mem) begin
        r_ex    <= ex_res;
        r_wdata <= r2_val_mem << {w_lane, 3'b000};
        r_strb  <= w_strb0 << w_lane;
        r_we    <= w_is_st;
        r_size  <= next_mem_operation_size;
        r_lane  <= w_lane;
        r_dst   <= mem_dst_reg;
        r_mis   <= w_mis;
      end
      if (r_state == WAIT && mem_rvalid) r_ldata <= w_ext;
    end
  end
  // Writeback register: holds until accepted; loaded by pass-through ops or on leaving DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_dst   <= 5'd0;
      r_wb_data  <= '0;
      r_wb_ecall <= 1'b0;
      r_wb_fault <= 1'b0;
    end else if (w_cap && !w_is_mem) begin
      r_wb_valid <= 1'b1;
      r_wb_dst   <= mem_dst_reg;
      r_wb_data  <= ex_res;
      r_wb_ecall <= ecall_mem;
      r_wb_fault <= 1'b0;
    end else if (r_state == DONE) begin
      r_wb_valid <= 1'b1;
      r_wb_dst   <= (r_we || r_mis) ? 5'd0 : r_dst;
      r_wb_data  <= r_mis ? r_ex : r_we ? '0 : r_ldata;
      r_wb_ecall <= 1'b0;
      r_wb_fault <= r_mis;
    end else if (wb_ready) begin
      r_wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_pipeline_mem.sv
// tb_pipeline_mem: directed self-checking bench for pipeline_mem.
module tb_pipeline_mem;
  logic        clk = 1'b0;
  logic        reset, in_valid, ready, ecall_mem;
  logic [63:0] ex_res, r2_val_mem, mem_addr, mem_wdata, mem_rdata, wb_data;
  logic [4:0]  mem_dst_reg, wb_dst_reg;
  logic [31:0] next_mem_opcode;
  logic [2:0]  next_mem_operation_size;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [7:0]  mem_wstrb;
  logic        wb_valid, wb_ready, wb_ecall, wb_fault;
  int          n_chk = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  pipeline_mem dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready), .ex_res(ex_res),
    .r2_val_mem(r2_val_mem), .mem_dst_reg(mem_dst_reg), .next_mem_opcode(next_mem_opcode),
    .next_mem_operation_size(next_mem_operation_size), .ecall_mem(ecall_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst_reg(wb_dst_reg), .wb_data(wb_data),
    .wb_ecall(wb_ecall), .wb_fault(wb_fault)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [63:0] ex, input logic [2:0] sz, input logic [4:0] dst,
                         input logic [63:0] rd);
    in_valid = 1; next_mem_opcode = 1; ex_res = ex; next_mem_operation_size = sz;
    mem_dst_reg = dst; ecall_mem = 0; mem_gnt = 1;
    tick;
    in_valid = 0; next_mem_opcode = 0;
    #1;
    chk("ld_req", mem_req, 1);
    chk("ld_addr", mem_addr, {ex[63:3], 3'b000});
    chk("ld_we", mem_we, 0);
    chk("ld_ready", ready, 0);
    tick;
    mem_gnt = 0; mem_rvalid = 1; mem_rdata = rd;
    tick;
    mem_rvalid = 0;
    chk("ld_latency", wb_valid, 0);
    tick;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; in_valid = 0; ex_res = 0; r2_val_mem = 0; mem_dst_reg = 0; next_mem_opcode = 0;
    next_mem_operation_size = 0; ecall_mem = 0; mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    wb_ready = 1;
    tick; tick;
    chk("rst_ready", ready, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_wbv", wb_valid, 0);
    reset = 0;
    #1;
    chk("post_rst_ready", ready, 1);
    in_valid = 1; ex_res = 64'h1234; mem_dst_reg = 5;
    tick;
    chk("nm_valid", wb_valid, 1);
    chk("nm_data", wb_data, 64'h1234);
    chk("nm_dst", wb_dst_reg, 5);
    chk("nm_ready", ready, 1);
    ex_res = 64'h55; mem_dst_reg = 6;
    tick;
    chk("b2b_data", wb_data, 64'h55);
    chk("b2b_dst", wb_dst_reg, 6);
    next_mem_opcode = 1; ecall_mem = 1; ex_res = 64'h77; mem_dst_reg = 8;
    tick;
    chk("ecall_flag", wb_ecall, 1);
    chk("ecall_data", wb_data, 64'h77);
    chk("ecall_noreq", mem_req, 0);
    in_valid = 0; ecall_mem = 0; next_mem_opcode = 0;
    tick;
    chk("nm_drain", wb_valid, 0);
    do_load(64'h1003, 3'b000, 7, 64'h0000_0000_80FF_0000);
    chk("lb_valid", wb_valid, 1);
    chk("lb_data", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_dst", wb_dst_reg, 7);
    do_load(64'h1003, 3'b100, 7, 64'h0000_0000_80FF_0000);
    chk("lbu_data", wb_data, 64'h80);
    in_valid = 1; next_mem_opcode = 2; ex_res = 64'h2004; r2_val_mem = 64'hDEAD_BEEF;
    next_mem_operation_size = 3'b010; mem_dst_reg = 12; mem_gnt = 0;
    tick;
    in_valid = 0; next_mem_opcode = 0;
    for (int i = 0; i < 3; i++) begin
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_strb", mem_wstrb, 8'hF0);
      chk("st_wdata", mem_wdata, 64'hDEAD_BEEF_0000_0000);
      chk("st_addr", mem_addr, 64'h2000);
      chk("st_ready", ready, 0);
      tick;
    end
    mem_gnt = 1;
    tick;
    mem_gnt = 0;
    chk("st_done_req", mem_req, 0);
    chk("st_done_wbv", wb_valid, 0);
    tick;
    chk("st_wbv", wb_valid, 1);
    chk("st_dst", wb_dst_reg, 0);
    chk("st_data", wb_data, 0);
    wb_ready = 0; in_valid = 1; ex_res = 64'h99; mem_dst_reg = 9;
    #1;
    chk("stall_ready", ready, 0);
    tick;
    chk("stall_wbv", wb_valid, 1);
    chk("stall_dst", wb_dst_reg, 0);
    tick;
    chk("stall_data", wb_data, 0);
    wb_ready = 1;
    #1;
    chk("release_ready", ready, 1);
    tick;
    chk("release_data", wb_data, 64'h99);
    chk("release_dst", wb_dst_reg, 9);
    in_valid = 0;
    tick;
    chk("release_drain", wb_valid, 0);
    in_valid = 1; next_mem_opcode = 1; ex_res = 64'h1000; next_mem_operation_size = 3'b011;
    mem_dst_reg = 4; mem_gnt = 1;
    tick;
    in_valid = 0; next_mem_opcode = 0;
    tick;
    mem_gnt = 0; reset = 1;
    tick;
    chk("rst_wait_req", mem_req, 0);
    chk("rst_wait_wbv", wb_valid, 0);
    reset = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick;
    mem_rvalid = 0;
    chk("stray_wbv", wb_valid, 0);
    tick; tick;
    chk("stray_wbv2", wb_valid, 0);
    chk("stray_ready", ready, 1);
`ifdef MEM_MISALIGN_CHECK_EN
    in_valid = 1; next_mem_opcode = 1; ex_res = 64'h3003; next_mem_operation_size = 3'b001;
    mem_dst_reg = 3; mem_gnt = 1;
    tick;
    in_valid = 0; next_mem_opcode = 0;
    chk("mis_noreq", mem_req, 0);
    tick;
    chk("mis_noreq2", mem_req, 0);
    chk("mis_wbv", wb_valid, 1);
    chk("mis_fault", wb_fault, 1);
    chk("mis_data", wb_data, 64'h3003);
    chk("mis_dst", wb_dst_reg, 0);
    mem_gnt = 0;
`else
    do_load(64'h3003, 3'b001, 3, 64'h0000_0000_8001_0000);
    chk("lh_wbv", wb_valid, 1);
    chk("lh_fault", wb_fault, 0);
    chk("lh_data", wb_data, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_dst", wb_dst_reg, 3);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
